// File: rtl/vid_timing_monitor.sv
// Measures hs/vs/de timing of a pixel stream, declares lock after LOCK_FRAMES identical frames.
// Optional active-pixel CRC-16-CCITT per frame is built when VTM_CRC_EN is defined.
module vid_timing_monitor #(
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int LOCK_FRAMES = 3,
  parameter int CW          = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_hs,
  input  logic          vid_vs,
  input  logic          vid_de,
  input  logic [7:0]    vid_r,
  input  logic [7:0]    vid_g,
  input  logic [7:0]    vid_b,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          frame_valid,
  output logic          locked,
  output logic          timing_change,
  output logic          overflow,
  output logic [15:0]   frame_crc
);

  localparam logic          HS_ACT  = (HS_POL != 0);
  localparam logic          VS_ACT  = (VS_POL != 0);
  localparam int            LOCK_M1 = LOCK_FRAMES - 1;
  localparam logic [CW-1:0] MAX     = '1;
  localparam int            SW      = 4 * CW + 16;

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? MAX : v + 1'b1;
  endfunction

  logic          hs_p0, vs_p0, de_p0, hs_p1, vs_p1;
  logic          hs_edge, vs_edge, timeout, sat_any, same;
  logic [CW-1:0] hcnt, decnt, vcnt, actl, line_len, line_act;
  logic [CW-1:0] len_end, act_end, vcnt_end, actl_end;
  logic [15:0]   crc_end;
  logic [SW-1:0] new_set, ref_set;
  logic [3:0]    match;
  state_t        state, state_nxt;
  logic          upd_out, load_ref, inc_match, clr_match, tchg;

  // p0: registered inputs, p1: delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_p0 <= 1'b0;
      vs_p0 <= 1'b0;
      de_p0 <= 1'b0;
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      hs_p0 <= vid_hs;
      vs_p0 <= vid_vs;
      de_p0 <= vid_de;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
    end
  end

  assign hs_edge = (hs_p0 == HS_ACT) && (hs_p1 != HS_ACT);
  assign vs_edge = (vs_p0 == VS_ACT) && (vs_p1 != VS_ACT);

  // Values as they stand once the current hs_edge line is folded into the frame
  always_comb begin
    len_end  = line_len;
    act_end  = line_act;
    vcnt_end = vcnt;
    actl_end = actl;
    if (hs_edge) begin
      len_end  = sat_inc(hcnt);
      vcnt_end = sat_inc(vcnt);
      if (decnt != '0) begin
        act_end  = decnt;
        actl_end = sat_inc(actl);
      end
    end
  end

  assign sat_any = (hcnt == MAX) || (decnt == MAX) || (vcnt_end == MAX) || (actl_end == MAX);
  assign timeout = (hcnt == MAX) && !hs_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt     <= '0;
      decnt    <= '0;
      vcnt     <= '0;
      actl     <= '0;
      line_len <= '0;
      line_act <= '0;
      overflow <= 1'b0;
    end else begin
      hcnt     <= hs_edge ? '0 : sat_inc(hcnt);
      decnt    <= hs_edge ? '0 : (de_p0 ? sat_inc(decnt) : decnt);
      line_len <= len_end;
      line_act <= act_end;
      vcnt     <= vs_edge ? '0 : vcnt_end;
      actl     <= vs_edge ? '0 : actl_end;
      if (sat_any) overflow <= 1'b1;
    end
  end

`ifdef VTM_CRC_EN
  logic [23:0] rgb_p0;
  logic [15:0] crc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 7; i >= 0; i--)
      x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return x;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p0 <= '0;
      crc    <= '0;
    end else begin
      rgb_p0 <= {vid_r, vid_g, vid_b};
      if (vs_edge)
        crc <= 16'hFFFF;
      else if (de_p0)
        crc <= crc_byte(crc_byte(crc_byte(crc, rgb_p0[23:16]), rgb_p0[15:8]), rgb_p0[7:0]);
    end
  end

  assign crc_end = crc;
`else
  logic unused_rgb;
  assign unused_rgb = ^{vid_r, vid_g, vid_b};
  assign crc_end    = 16'h0000;
`endif

  assign new_set = {len_end, act_end, vcnt_end, actl_end, crc_end};
  assign same    = (new_set == ref_set);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout)
      state_nxt = IDLE;
    else if (vs_edge) begin
      case (state)
        IDLE:    state_nxt = MEASURE;
        MEASURE: state_nxt = CHECK;
        CHECK:   if (same && ((int'(match) + 1) >= LOCK_M1)) state_nxt = LOCKED;
        LOCKED:  if (!same) state_nxt = CHECK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    upd_out   = 1'b0;
    load_ref  = 1'b0;
    inc_match = 1'b0;
    clr_match = 1'b0;
    tchg      = 1'b0;
    if (!timeout && vs_edge) begin
      case (state)
        MEASURE: begin
          upd_out   = 1'b1;
          load_ref  = 1'b1;
          clr_match = 1'b1;
        end
        CHECK: begin
          upd_out = 1'b1;
          if (same) inc_match = 1'b1;
          else begin
            load_ref  = 1'b1;
            clr_match = 1'b1;
          end
        end
        LOCKED: begin
          upd_out = 1'b1;
          if (!same) begin
            load_ref  = 1'b1;
            clr_match = 1'b1;
            tchg      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status and measurement outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_total       <= '0;
      h_active      <= '0;
      v_total       <= '0;
      v_active      <= '0;
      frame_crc     <= '0;
      frame_valid   <= 1'b0;
      timing_change <= 1'b0;
      locked        <= 1'b0;
      ref_set       <= '0;
      match         <= '0;
    end else begin
      frame_valid   <= upd_out;
      timing_change <= tchg;
      locked        <= (state_nxt == LOCKED);
      if (upd_out) begin
        h_total   <= len_end;
        h_active  <= act_end;
        v_total   <= vcnt_end;
        v_active  <= actl_end;
        frame_crc <= crc_end;
      end
      if (load_ref) ref_set <= new_set;
      if (clr_match)      match <= '0;
      else if (inc_match) match <= match + 1'b1;
    end
  end

endmodule

// File: tb/tb_vid_timing_monitor.sv
// Bench for vid_timing_monitor: two instances (active-high/LOCK_FRAMES=3, active-low/LOCK_FRAMES=1)
// driven by one synthetic stream and checked against a frame-level model.
module tb_vid_timing_monitor;

  localparam int CW = 12;
`ifdef VTM_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic vid_hs, vid_vs, vid_de, hs_n, vs_n;
  logic [7:0] vid_r, vid_g, vid_b;
  logic [CW-1:0] a_ht, a_ha, a_vt, a_va, b_ht, b_ha, b_vt, b_va;
  logic a_fv, a_lk, a_tc, a_ovf, b_fv, b_lk, b_tc, b_ovf;
  logic [15:0] a_crc, b_crc;

  always #5 clk = ~clk;
  assign hs_n = ~vid_hs;
  assign vs_n = ~vid_vs;

  vid_timing_monitor #(.HS_POL(1), .VS_POL(1), .LOCK_FRAMES(3), .CW(CW)) dut_a (
    .clk(clk), .reset(reset), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .h_total(a_ht), .h_active(a_ha), .v_total(a_vt), .v_active(a_va),
    .frame_valid(a_fv), .locked(a_lk), .timing_change(a_tc), .overflow(a_ovf), .frame_crc(a_crc));

  vid_timing_monitor #(.HS_POL(0), .VS_POL(0), .LOCK_FRAMES(1), .CW(CW)) dut_b (
    .clk(clk), .reset(reset), .vid_hs(hs_n), .vid_vs(vs_n), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .h_total(b_ht), .h_active(b_ha), .v_total(b_vt), .v_active(b_va),
    .frame_valid(b_fv), .locked(b_lk), .timing_change(b_tc), .overflow(b_ovf), .frame_crc(b_crc));

  int n_cmp = 0;
  int n_err = 0;
  int fv_seen, tc_seen;

  // Frame-level model: previous frame, reference frame, expected outputs
  bit armed, have_ref, lk_a, lk_b, tc_a, tc_b, efv, exp_ovf;
  int run;
  int p_ht, p_ha, p_vt, p_va, r_ht, r_ha, r_vt, r_va, e_ht, e_ha, e_vt, e_va;
  logic [15:0] p_crc, r_crc, e_crc;
  int m_ht, m_ha, m_vt, m_va;
  logic [23:0] m_pix;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 7; i >= 0; i--)
      x = (x[15] ^ d[i]) ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  function automatic int lock_thr(input int lf);
    return (lf < 2) ? 2 : lf;
  endfunction

  task automatic model_reset();
    armed = 0; have_ref = 0; run = 0;
    lk_a = 0; lk_b = 0; tc_a = 0; tc_b = 0; efv = 0; exp_ovf = 0;
    e_ht = 0; e_ha = 0; e_vt = 0; e_va = 0; e_crc = 16'h0;
  endtask

  task automatic model_vs();
    bit same, was_a, was_b;
    tc_a = 0; tc_b = 0;
    if (!armed) begin
      armed = 1;
      efv   = 0;
    end else begin
      efv  = 1;
      same = have_ref && p_ht == r_ht && p_ha == r_ha && p_vt == r_vt && p_va == r_va &&
             (!CRC_ON || p_crc == r_crc);
      run   = same ? run + 1 : 1;
      was_a = lk_a;
      was_b = lk_b;
      lk_a  = run >= lock_thr(3);
      lk_b  = run >= lock_thr(1);
      tc_a  = was_a && !same;
      tc_b  = was_b && !same;
      have_ref = 1;
      r_ht = p_ht; r_ha = p_ha; r_vt = p_vt; r_va = p_va; r_crc = p_crc;
      e_ht = p_ht; e_ha = p_ha; e_vt = p_vt; e_va = p_va;
      e_crc = CRC_ON ? p_crc : 16'h0;
    end
  endtask

  task automatic check_vs();
    chk("frame_valid_a", a_fv, efv);
    chk("frame_valid_b", b_fv, efv);
    chk("locked_a", a_lk, lk_a);
    chk("locked_b", b_lk, lk_b);
    chk("timing_change_a", a_tc, tc_a);
    chk("timing_change_b", b_tc, tc_b);
    chk("timing_a", {a_ht, a_ha, a_vt, a_va}, {12'(e_ht), 12'(e_ha), 12'(e_vt), 12'(e_va)});
    chk("timing_b", {b_ht, b_ha, b_vt, b_va}, {12'(e_ht), 12'(e_ha), 12'(e_vt), 12'(e_va)});
    chk("overflow_a", a_ovf, exp_ovf);
    chk("frame_crc_a", a_crc, e_crc);
    chk("frame_crc_b", b_crc, e_crc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_timing_a"}, {a_ht, a_ha, a_vt, a_va}, 64'h0);
    chk({tag, "_status_a"}, {a_fv, a_lk, a_tc, a_ovf, a_crc}, 64'h0);
    chk({tag, "_timing_b"}, {b_ht, b_ha, b_vt, b_va}, 64'h0);
    chk({tag, "_status_b"}, {b_fv, b_lk, b_tc, b_ovf, b_crc}, 64'h0);
  endtask

  // One frame: hs for 2 clk at each line start, vs over lines 0-1, de over
  // lines [2, 2+va) and pixels [4, 4+ha). Outputs for the previous frame are checked at p=2/3 of line 0.
  task automatic send_frame(input int ht, input int ha, input int vt, input int va,
                            input logic [23:0] pix, input int flip_l, input int rst_at);
    logic [15:0] c;
    logic [23:0] d;
    bit de;
    c = 16'hFFFF;
    for (int l = 0; l < vt; l++) begin
      for (int p = 0; p < ht; p++) begin
        @(negedge clk);
        if (l == 0 && p == 2) check_vs();
        if (l == 0 && p == 3) begin
          chk("frame_valid_pulse_a", a_fv, 1'b0);
          chk("timing_change_pulse_a", a_tc, 1'b0);
        end
        if (rst_at == l * ht + p) begin
          #1 reset = 1'b1;
          #1;
          check_zero("async_reset");
          model_reset();
          #1 reset = 1'b0;
        end
        de = (l >= 2) && (l < 2 + va) && (p >= 4) && (p < 4 + ha);
        d  = (l == flip_l && p == 4) ? (pix ^ 24'h000001) : pix;
        vid_hs = (p < 2);
        vid_vs = (l < 2);
        vid_de = de;
        {vid_r, vid_g, vid_b} = de ? d : 24'h0;
        if (de) c = crc_byte(crc_byte(crc_byte(c, d[23:16]), d[15:8]), d[7:0]);
        if (l == 0 && p == 0) model_vs();
      end
    end
    p_ht = ht; p_ha = ha; p_vt = vt; p_va = va; p_crc = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_fv || b_fv) fv_seen++;
      if (a_tc || b_tc) tc_seen++;
      vid_hs = 1'b0;
      vid_vs = 1'b0;
      vid_de = 1'b0;
      {vid_r, vid_g, vid_b} = 24'h0;
    end
  endtask

  initial begin
    reset = 1'b1;
    vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0;
    {vid_r, vid_g, vid_b} = 24'h0;
    fv_seen = 0; tc_seen = 0;
    p_ht = 0; p_ha = 0; p_vt = 0; p_va = 0; p_crc = 16'h0;
    r_ht = 0; r_ha = 0; r_vt = 0; r_va = 0; r_crc = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    // Nominal mode, lock on 4th vs (A) / 3rd vs (B)
    repeat (5) send_frame(20, 12, 10, 6, 24'h102030, -1, -1);
    // Line length change while locked, then relock
    repeat (4) send_frame(21, 12, 10, 6, 24'h102030, -1, -1);
    // One altered pixel in a locked frame
    send_frame(21, 12, 10, 6, 24'h102030, 3, -1);
    repeat (3) send_frame(21, 12, 10, 6, 24'h102030, -1, -1);

    for (int m = 0; m < 3; m++) begin
      m_ht  = $urandom_range(40, 20);
      m_ha  = $urandom_range(m_ht - 6, 1);
      m_vt  = $urandom_range(14, 6);
      m_va  = $urandom_range(m_vt - 3, 1);
      m_pix = 24'($urandom);
      repeat (4) send_frame(m_ht, m_ha, m_vt, m_va, m_pix, -1, -1);
    end

    // Sync loss: saturating line counter drops lock without timing_change
    repeat (5) send_frame(20, 12, 10, 6, 24'h102030, -1, -1);
    idle(3900);
    chk("pre_timeout_overflow_a", a_ovf, 1'b0);
    chk("pre_timeout_locked_a", a_lk, lk_a);
    chk("pre_timeout_locked_b", b_lk, lk_b);
    idle(300);
    chk("timeout_overflow_a", a_ovf, 1'b1);
    chk("timeout_overflow_b", b_ovf, 1'b1);
    chk("timeout_locked_a", a_lk, 1'b0);
    chk("timeout_locked_b", b_lk, 1'b0);
    chk("timeout_tchange_count", tc_seen, 0);
    chk("timeout_fvalid_count", fv_seen, 0);
    armed = 0; have_ref = 0; run = 0; lk_a = 0; lk_b = 0; exp_ovf = 1;

    repeat (5) send_frame(20, 12, 10, 6, 24'h102030, -1, -1);
    // Reset mid-line while locked
    send_frame(20, 12, 10, 6, 24'h102030, -1, 3 * 20 + 7);
    repeat (4) send_frame(20, 12, 10, 6, 24'h102030, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vid_timing_monitor.md
Name: vid_timing_monitor

Overview:
- Sits directly downstream of the VGA/HDMI pattern generator on the pixel-clock domain.
- Consumes hs/vs/de (and RGB) and measures the running timing: line length, active pixels per line, lines per frame, active lines.
- Declares lock after N identical frames and flags timing changes, for status registers and bring-up of new video modes.

Parameters:
- HS_POL, 1, hsync asserted level (1 = active high)
- VS_POL, 1, vsync asserted level
- LOCK_FRAMES, 3, consecutive matching frames required for lock (1..15)
- CW, 12, width of all measurement counters and outputs

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vid_hs  in  1  horizontal sync from generator
- vid_vs  in  1  vertical sync from generator
- vid_de  in  1  data enable
- vid_r / vid_g / vid_b  in  8 each  pixel data (used only by the optional feature)
- h_total  out  CW  clocks per line, last completed frame
- h_active  out  CW  de-high clocks per active line
- v_total  out  CW  lines per frame
- v_active  out  CW  lines containing at least one de cycle
- frame_valid  out  1  one-cycle pulse when the outputs above update
- locked  out  1  timing stable
- timing_change  out  1  one-cycle pulse on loss of lock caused by a mismatch
- overflow  out  1  sticky; a counter saturated since last reset
- frame_crc  out  16  active-pixel CRC of last frame (optional feature)

Behaviour:
- Reset: all outputs and internal state 0; FSM = IDLE.
- Input stage: hs/vs/de/rgb registered once. hs_edge / vs_edge = transition into the asserted level (polarity per parameter), detected on the registered copy. Latency from input edge to internal event: 2 clk.
- hcnt: cleared to 0 on hs_edge, else +1. On hs_edge, line_len = hcnt+1.
- decnt: counts registered de=1 cycles, cleared on hs_edge. On hs_edge with decnt != 0: line_act = decnt, and actl +1.
- vcnt: +1 per hs_edge, cleared on vs_edge.
- On vs_edge, capture {line_len, line_act, vcnt, actl} into a new-frame set; vcnt and actl are cleared the same cycle.
- Simultaneous hs_edge and vs_edge: the hs_edge line is counted into the ending frame first; the next frame then starts at vcnt=0.
- Saturation: any counter reaching 2^CW-1 holds and sets overflow (sticky). hcnt saturation also forces FSM to IDLE with locked=0; this is the no-sync timeout. No timing_change pulse in that case.
- FSM:
  - IDLE: on vs_edge go to MEASURE. The partial frame is discarded and no outputs update.
  - MEASURE: on vs_edge, store the new-frame set as ref, drive outputs, pulse frame_valid, match=0, go to CHECK.
  - CHECK: on vs_edge, drive outputs and pulse frame_valid.
    - If new == ref: match+1; when match+1 == LOCK_FRAMES-1 go to LOCKED and set locked=1 the same cycle as frame_valid.
    - Else: ref=new, match=0.
  - LOCKED: on vs_edge, drive outputs and pulse frame_valid.
    - If new != ref: locked=0, timing_change=1 for one cycle, ref=new, match=0, go to CHECK.
- LOCK_FRAMES=1: lock is declared on the first compared match.
- Outputs are registered. They change only in the frame_valid cycle, which is 2 clk after the vs input edge.
- Reset mid-frame: everything clears immediately; the next partial frame is discarded via IDLE.

Optional Feature:
- Macro VTM_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) over R, G, B bytes, MSB first, for each registered de=1 cycle. Re-init on vs_edge after the value is latched into frame_crc, which updates with frame_valid. A CRC mismatch also counts as a frame mismatch in CHECK/LOCKED.
- Undefined: no CRC logic; frame_crc tied to 0; compare uses timing only.

Test Plan:
- Synthetic timing h_total=20, de 12 clk/line, v_total=10, 6 active lines, LOCK_FRAMES=3, sync active high -> frame_valid each frame with 20/12/10/6 starting at 2nd vs; locked=1 at the 4th vs edge after reset.
- Locked stream, then one frame with h_total=21 -> timing_change pulse and locked=0 at that frame's end; relock after 2 further 21-clk frames.
- Stop hs/vs after lock -> after 4095 clk overflow=1, locked=0, no timing_change; resume -> lock again after 1 discarded + 3 frames.
- HS_POL=0/VS_POL=0 with 720p constants (1650/1280/750/720) -> outputs 1650, 1280, 750, 720; locked after the 4th vs.
- Assert reset mid-line while locked -> all outputs 0 the same cycle; first post-reset frame produces no frame_valid.
- VTM_CRC_EN, constant pixel 0x102030 over 12x6 active -> frame_crc equals the software model. Flip one pixel in a locked frame -> timing_change.
